// File: rtl/bram_port_arbiter_pkg.sv
// Shared widths, requester IDs and lock bound for the two-master BRAM port arbiter.
package bram_port_arbiter_pkg;

   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_MAX_LOCK = 4;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/bram_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, ties go to ptr.
// Output is one-hot or zero.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req[0] && (!req[1] || !ptr);
      gnt[1] = req[1] && (!req[0] ||  ptr);
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one registered-output BRAM port between two masters: round-robin grant in the
// request cycle, read data returned one cycle later, bounded lock for back-to-back access.
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_LOCK = DEF_MAX_LOCK
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int            CW       = $clog2(MAX_LOCK);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

   logic          ptr;
   logic          owner;
   logic          lock_prev;
   logic [CW-1:0] lock_cnt;
   logic          rd_pend;
   logic          rd_id;

   logic [1:0] req_v;
   logic [1:0] pick;
   logic [1:0] gnt_v;
   logic       hold;
   logic       winner;
   logic       any;
   logic       win_lock;

   assign req_v = {req1, req0};

   // The hold only continues while the owner keeps requesting; dropping req ends it at once.
   assign hold = lock_prev && req_v[owner] && (lock_cnt < CNT_LAST);

   rr_pick2 u_pick (
      .req (req_v),
      .ptr (ptr),
      .gnt (pick)
   );

   always_comb begin
      gnt_v = pick;
      if (rst)
         gnt_v = 2'b00;
      else if (hold)
         gnt_v = (owner == REQ1) ? 2'b10 : 2'b01;
   end

   assign gnt0     = gnt_v[0];
   assign gnt1     = gnt_v[1];
   assign winner   = gnt_v[1];
   assign any      = |gnt_v;
   assign win_lock = winner ? lock1 : lock0;

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_we   = 1'b0;
      if (gnt_v[1]) begin
         mem_addr = addr1;
         mem_din  = wdata1;
         mem_we   = we1;
      end else if (gnt_v[0]) begin
         mem_addr = addr0;
         mem_din  = wdata0;
         mem_we   = we0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= 1'b0;
         owner     <= 1'b0;
         lock_prev <= 1'b0;
         lock_cnt  <= '0;
         rd_pend   <= 1'b0;
         rd_id     <= 1'b0;
      end else begin
         lock_prev <= 1'b0;
         rd_pend   <= any && !mem_we;
         if (any) begin
            owner     <= winner;
            ptr       <= ~winner;
            lock_prev <= win_lock;
            lock_cnt  <= hold ? lock_cnt + CW'(1) : '0;
            if (!mem_we)
               rd_id <= winner;
         end
      end
   end

   assign rvalid0 = !rst && rd_pend && (rd_id == REQ0);
   assign rvalid1 = !rst && rd_pend && (rd_id == REQ1);
   assign rdata0  = mem_dout;
   assign rdata1  = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a behavioural registered-read RAM.
module tb_bram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
   logic [9:0]  addr0 = '0, addr1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [15:0] rdata0, rdata1, mem_din, mem_dout;
   logic [9:0]  mem_addr;
   logic [15:0] ram [0:1023];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   bram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic sample;
      @(negedge clk);
   endtask

   task automatic set0(input logic r, input logic w, input logic l, input logic [9:0] a, input logic [15:0] d);
      req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic l, input logic [9:0] a, input logic [15:0] d);
      req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
   endtask

   task automatic test_reset;
      set0(1, 0, 0, 10'd5, 16'h0); set1(1, 0, 0, 10'd1, 16'h0);
      repeat (2) @(posedge clk);
      sample;
      checks++; if ({gnt1, gnt0} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {gnt1, gnt0}); end
      checks++; if ({rvalid1, rvalid0, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_rv_we got %b exp 000", {rvalid1, rvalid0, mem_we}); end
      checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", mem_addr); end
      tick; rst = 0; set1(0, 0, 0, 10'd1, 16'h0);
      sample;
      checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL reset_first_gnt0 got %b exp 1", gnt0); end
      tick; set0(1, 1, 0, 10'd5, 16'h1234);
      sample;
      checks++; if ({gnt0, mem_we, rvalid0} !== 3'b111) begin errors++; $display("FAIL pre_rst_active got %b exp 111", {gnt0, mem_we, rvalid0}); end
      #1 rst = 1;
      #1;
      checks++; if ({gnt0, gnt1, mem_we, rvalid0, rvalid1} !== 5'b00000) begin errors++; $display("FAIL async_rst got %b exp 00000", {gnt0, gnt1, mem_we, rvalid0, rvalid1}); end
      checks++; if (mem_din !== 16'h0) begin errors++; $display("FAIL async_rst_din got %h exp 0000", mem_din); end
      tick; rst = 0; set0(1, 0, 0, 10'd0, 16'h0); set1(1, 0, 0, 10'd1, 16'h0);
      sample;
      checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL post_rst_both got %b exp 01", {gnt1, gnt0}); end
      checks++; if ({rvalid1, rvalid0} !== 2'b00) begin errors++; $display("FAIL dropped_read got %b exp 00", {rvalid1, rvalid0}); end
      tick; set0(0, 0, 0, 10'd0, 16'h0); set1(0, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if ({rvalid1, rvalid0} !== 2'b01) begin errors++; $display("FAIL post_rst_rvalid got %b exp 01", {rvalid1, rvalid0}); end
      tick;
   endtask

   task automatic test_single_read;
      set1(1, 1, 0, 10'd3, 16'h00A5);
      sample;
      checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL sr_preload_gnt1 got %b exp 1", gnt1); end
      tick; set1(1, 0, 0, 10'd3, 16'h0);
      sample;
      checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL sr_gnt got %b exp 10", {gnt1, gnt0}); end
      checks++; if (mem_addr !== 10'd3 || mem_we !== 1'b0) begin errors++; $display("FAIL sr_port got addr %0d we %b exp addr 3 we 0", mem_addr, mem_we); end
      tick; set1(0, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if ({rvalid1, rvalid0} !== 2'b10) begin errors++; $display("FAIL sr_rvalid got %b exp 10", {rvalid1, rvalid0}); end
      checks++; if (rdata1 !== 16'h00A5) begin errors++; $display("FAIL sr_rdata1 got %h exp 00a5", rdata1); end
      tick;
   endtask

   task automatic test_contention;
      for (int k = 0; k < 4; k++) begin
         set0(1, 1, 0, 10'd10, 16'(1 + k)); set1(1, 1, 0, 10'd20, 16'(100 + k));
         sample;
         checks++; if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL cont_gnt[%0d] got %b exp %b", k, {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10); end
         tick;
      end
      set0(1, 0, 0, 10'd10, 16'h0); set1(1, 0, 0, 10'd20, 16'h0);
      sample;
      checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL cont_rd0_gnt got %b exp 01", {gnt1, gnt0}); end
      tick; set0(0, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if (gnt1 !== 1'b1 || rvalid0 !== 1'b1 || rdata0 !== 16'd3) begin errors++; $display("FAIL cont_ram10 got gnt1 %b rv0 %b data %0d exp 1 1 3", gnt1, rvalid0, rdata0); end
      tick; set1(0, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if (rvalid1 !== 1'b1 || rdata1 !== 16'd103) begin errors++; $display("FAIL cont_ram20 got rv1 %b data %0d exp 1 103", rvalid1, rdata1); end
      tick;
   endtask

   task automatic test_lock_release;
      logic [9:0] exp1;
      exp1 = 10'b10_0001_0000;
      set0(1, 1, 1, 10'd30, 16'h0); set1(1, 1, 0, 10'd31, 16'h0);
      for (int k = 0; k < 10; k++) begin
         sample;
         checks++; if (gnt1 !== exp1[k] || gnt0 !== !exp1[k]) begin errors++; $display("FAIL lock_gnt[%0d] got %b exp %b", k, {gnt1, gnt0}, {exp1[k], !exp1[k]}); end
         tick;
      end
      set0(0, 0, 0, 10'd0, 16'h0); set1(0, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if ({gnt1, gnt0} !== 2'b00) begin errors++; $display("FAIL lock_idle got %b exp 00", {gnt1, gnt0}); end
      tick;
   endtask

   task automatic test_rmw;
      set1(1, 1, 0, 10'd7, 16'd4);
      sample;
      tick; set0(1, 0, 1, 10'd7, 16'h0); set1(1, 1, 0, 10'd40, 16'd9);
      sample;
      checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL rmw_read_gnt got %b exp 01", {gnt1, gnt0}); end
      tick; set0(1, 1, 0, 10'd7, 16'd5);
      sample;
      checks++; if ({gnt1, gnt0} !== 2'b01 || mem_we !== 1'b1) begin errors++; $display("FAIL rmw_write_gnt got %b we %b exp 01 1", {gnt1, gnt0}, mem_we); end
      checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'd4) begin errors++; $display("FAIL rmw_rdata got rv0 %b data %0d exp 1 4", rvalid0, rdata0); end
      tick; set0(0, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL rmw_contender got %b exp 10", {gnt1, gnt0}); end
      tick; set1(0, 0, 0, 10'd0, 16'h0); set0(1, 0, 0, 10'd7, 16'h0);
      sample;
      tick; set0(0, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'd5) begin errors++; $display("FAIL rmw_ram7 got rv0 %b data %0d exp 1 5", rvalid0, rdata0); end
      tick;
   endtask

   task automatic test_back_to_back;
      set0(1, 1, 0, 10'd0, 16'h1111);
      sample;
      tick; set0(1, 1, 0, 10'd1, 16'h2222);
      sample;
      tick; set0(1, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if (gnt0 !== 1'b1 || {rvalid1, rvalid0} !== 2'b00) begin errors++; $display("FAIL b2b_first got gnt0 %b rv %b exp 1 00", gnt0, {rvalid1, rvalid0}); end
      tick; set0(0, 0, 0, 10'd0, 16'h0); set1(1, 0, 0, 10'd1, 16'h0);
      sample;
      checks++; if (gnt1 !== 1'b1 || {rvalid1, rvalid0} !== 2'b01 || rdata0 !== 16'h1111) begin errors++; $display("FAIL b2b_n1 got gnt1 %b rv %b data %h exp 1 01 1111", gnt1, {rvalid1, rvalid0}, rdata0); end
      tick; set1(0, 0, 0, 10'd0, 16'h0);
      sample;
      checks++; if ({rvalid1, rvalid0} !== 2'b10 || rdata1 !== 16'h2222) begin errors++; $display("FAIL b2b_n2 got rv %b data %h exp 10 2222", {rvalid1, rvalid0}, rdata1); end
      tick;
      sample;
      checks++; if ({rvalid1, rvalid0} !== 2'b00) begin errors++; $display("FAIL b2b_n3 got rv %b exp 00", {rvalid1, rvalid0}); end
      tick;
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_contention;
      test_lock_release;
      test_rmw;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
